// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response signals plus the 16-bit asynchronous SRAM pad
// signals of the multi-cycle data memory controller.
interface sram_ctrl_if #(
  parameter int unsigned SRAM_AW = 18
);
  logic               MEM_R_EN;
  logic               MEM_W_EN;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [15:0]        SRAM_DQ_O;
  logic [15:0]        SRAM_DQ_I;
  logic               SRAM_DQ_OE;
  logic               SRAM_WE_N;
  logic               SRAM_OE_N;

  // Controller side
  modport slave (
    input  MEM_R_EN, MEM_W_EN, addr, wdata, SRAM_DQ_I,
    output rdata, ready, SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N
  );

  // Pipeline plus SRAM device side
  modport master (
    output MEM_R_EN, MEM_W_EN, addr, wdata, SRAM_DQ_I,
    input  rdata, ready, SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_ctrl.sv
// Multi-cycle data memory controller: each 32-bit load/store becomes two 16-bit
// accesses to an asynchronous SRAM while ready is held low to freeze the pipeline.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = SRAM_AW - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]         state,    state_nxt;
  logic [CNT_W-1:0]   cnt,      cnt_nxt;
  logic               op_wr,    op_wr_nxt;
  logic [WORD_W-1:0]  word,     word_nxt;
  logic [31:0]        wd,       wd_nxt;
  logic [31:0]        rdata_q,  rdata_nxt;
  logic [SRAM_AW-1:0] addr_q,   addr_nxt;
  logic [15:0]        dq_o_q,   dq_o_nxt;
  logic               dq_oe_q,  dq_oe_nxt;
  logic               we_n_q,   we_n_nxt;
  logic               oe_n_q,   oe_n_nxt;

  logic               req_c;
  logic               last_c;
  logic [31:0]        offset_c;
  logic               unused_offset_bits;

  assign req_c    = bus.MEM_R_EN | bus.MEM_W_EN;
  assign last_c   = (cnt == CNT_LAST);
  assign offset_c = bus.addr - 32'(BASE_ADDR);
  // Byte offset within the word and address bits beyond the SRAM are dropped
  assign unused_offset_bits = ^{offset_c[31:SRAM_AW+1], offset_c[1:0]};

  // Next state, datapath and pad outputs for the upcoming cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_wr_nxt = op_wr;
    word_nxt  = word;
    wd_nxt    = wd;
    rdata_nxt = rdata_q;
    addr_nxt  = '0;
    dq_o_nxt  = '0;
    dq_oe_nxt = 1'b0;
    we_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;

    case (state)
      IDLE: begin
        if (req_c) begin
          op_wr_nxt = bus.MEM_W_EN;
          word_nxt  = offset_c[SRAM_AW:2];
          wd_nxt    = bus.wdata;
          cnt_nxt   = '0;
          state_nxt = LO;
        end
      end
      LO: begin
        if (last_c) begin
          if (!op_wr) rdata_nxt[15:0] = bus.SRAM_DQ_I;
          cnt_nxt   = '0;
          state_nxt = HI;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (last_c) begin
          if (!op_wr) rdata_nxt[31:16] = bus.SRAM_DQ_I;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // WE_N rises on the last cycle of each half so data hold is met
    if (state_nxt == LO || state_nxt == HI) begin
      addr_nxt = {word_nxt, (state_nxt == HI)};
      if (op_wr_nxt) begin
        dq_oe_nxt = 1'b1;
        dq_o_nxt  = (state_nxt == HI) ? wd_nxt[31:16] : wd_nxt[15:0];
        we_n_nxt  = (cnt_nxt == CNT_LAST);
      end else begin
        oe_n_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      word    <= '0;
      wd      <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_wr   <= op_wr_nxt;
      word    <= word_nxt;
      wd      <= wd_nxt;
      rdata_q <= rdata_nxt;
      addr_q  <= addr_nxt;
      dq_o_q  <= dq_o_nxt;
      dq_oe_q <= dq_oe_nxt;
      we_n_q  <= we_n_nxt;
      oe_n_q  <= oe_n_nxt;
    end
  end

  // Combinational in IDLE so the freeze appears in the request cycle
  assign bus.ready      = (state == IDLE) ? ~req_c : (state == DONE);
  assign bus.rdata      = rdata_q;
  assign bus.SRAM_ADDR  = addr_q;
  assign bus.SRAM_DQ_O  = dq_o_q;
  assign bus.SRAM_DQ_OE = dq_oe_q;
  assign bus.SRAM_WE_N  = we_n_q;
  assign bus.SRAM_OE_N  = oe_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: cycle-indexed transaction model checked every cycle,
// with a small behavioural asynchronous SRAM attached to the pads.
module tb_sram_ctrl;

  localparam int unsigned W    = 4;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic clk;
  logic rst;

  sram_ctrl_if #(.SRAM_AW(AW)) bus ();

  sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: writes while WE_N is low, reads while OE_N is low
  logic [15:0] sram_mem [0:15];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= 16'h0;
      sram_mem[2] <= 16'h5678;
      sram_mem[3] <= 16'h1234;
    end else if (!bus.SRAM_WE_N && bus.SRAM_DQ_OE) begin
      sram_mem[bus.SRAM_ADDR[3:0]] <= bus.SRAM_DQ_O;
    end
  end
  assign bus.SRAM_DQ_I = !bus.SRAM_OE_N ? sram_mem[bus.SRAM_ADDR[3:0]] : 16'h0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: m_k is the cycle index since the request appeared
  int          m_k = -1;
  logic        m_wr;
  logic [16:0] m_word;
  logic [31:0] m_data;
  logic [31:0] exp_rdata = 32'h0;
  logic [15:0] ref_mem [0:15];
  logic        done_seen;
  int          we_low, oe_low, stall;

  task automatic model_check();
    logic        e_ready, e_we, e_oe, e_dqoe;
    logic [17:0] e_addr;
    logic [15:0] e_dqo;
    int          h, j;
    logic [3:0]  i0;
    if (m_k < 0 && rst && (bus.MEM_R_EN || bus.MEM_W_EN)) begin
      m_k    = 0;
      m_wr   = bus.MEM_W_EN;
      m_word = 17'((bus.addr - 32'(BASE)) >> 2);
      m_data = bus.wdata;
      we_low = 0; oe_low = 0; stall = 0;
      if (m_wr) begin
        i0 = 4'({m_word, 1'b0});
        ref_mem[i0]        = m_data[15:0];
        ref_mem[i0 + 4'd1] = m_data[31:16];
      end
    end
    e_ready = (m_k < 0) ? !(bus.MEM_R_EN || bus.MEM_W_EN) : (m_k == 2*W+1);
    e_addr = '0; e_dqo = '0; e_dqoe = 1'b0; e_we = 1'b1; e_oe = 1'b1;
    if (m_k >= 1 && m_k <= 2*W) begin
      h = (m_k - 1) / W;
      j = (m_k - 1) % W;
      e_addr = {m_word, h[0]};
      if (m_wr) begin
        e_dqoe = 1'b1;
        e_dqo  = h[0] ? m_data[31:16] : m_data[15:0];
        e_we   = (j == W-1);
      end else begin
        e_oe = 1'b0;
      end
    end
    chk("ready",     32'(bus.ready),      32'(e_ready));
    chk("rdata",     bus.rdata,           exp_rdata);
    chk("sram_addr", 32'(bus.SRAM_ADDR),  32'(e_addr));
    chk("dq_o",      32'(bus.SRAM_DQ_O),  32'(e_dqo));
    chk("dq_oe",     32'(bus.SRAM_DQ_OE), 32'(e_dqoe));
    chk("we_n",      32'(bus.SRAM_WE_N),  32'(e_we));
    chk("oe_n",      32'(bus.SRAM_OE_N),  32'(e_oe));
    if (m_k >= 0) begin
      if (!bus.SRAM_WE_N) we_low++;
      if (!bus.SRAM_OE_N) oe_low++;
      if (!bus.ready)     stall++;
      if (m_k == 2*W+1)   done_seen = 1'b1;
    end
  endtask

  task automatic model_advance();
    logic [3:0] i0;
    if (m_k >= 0) begin
      i0 = 4'({m_word, 1'b0});
      if (!m_wr && m_k == W)   exp_rdata[15:0]  = ref_mem[i0];
      if (!m_wr && m_k == 2*W) exp_rdata[31:16] = ref_mem[i0 + 4'd1];
      if (m_k == 2*W+1) m_k = -1;
      else              m_k++;
    end
  endtask

  // Inputs are set at the falling edge; check 1 time unit later
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    set_req(r, w, a, d);
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) cycle();
    if (!done_seen) chk("txn_timeout", 32'd0, 32'd1);
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
    ref_mem[2] = 16'h5678;
    ref_mem[3] = 16'h1234;
    rst = 1'b0;
    preload = 1'b1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready),      32'd1);
    chk("rst_rdata", bus.rdata,           32'd0);
    chk("rst_we_n",  32'(bus.SRAM_WE_N),  32'd1);
    chk("rst_oe_n",  32'(bus.SRAM_OE_N),  32'd1);
    chk("rst_dq_oe", 32'(bus.SRAM_DQ_OE), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Store 0xDEADBEEF at SRAM word 0
    run_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    chk("st_stall",  32'(stall),  32'd9);
    chk("st_we_low", 32'(we_low), 32'd6);
    chk("st_hw0",    32'(sram_mem[0]), 32'h0000BEEF);
    chk("st_hw1",    32'(sram_mem[1]), 32'h0000DEAD);

    // Load it back
    run_txn(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("ld_stall",  32'(stall),  32'd9);
    chk("ld_oe_low", 32'(oe_low), 32'd8);
    chk("ld_data",   bus.rdata,   32'hDEADBEEF);

    // Load with addr[1:0] = 2'b10 from preloaded word 1
    run_txn(1'b1, 1'b0, 32'd1030, 32'h0);
    chk("ld2_data",  bus.rdata,   32'h12345678);

    // Both enables: behaves as a write, rdata untouched
    run_txn(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A);
    chk("rw_hw2",    32'(sram_mem[2]), 32'h00005A5A);
    chk("rw_hw3",    32'(sram_mem[3]), 32'h0000A5A5);
    chk("rw_rdata",  bus.rdata,   32'h12345678);

    // Reset in the HI half of a load
    set_req(1'b1, 1'b0, 32'd1024, 32'h0);
    for (int c = 0; c < W + 2; c++) cycle();
    rst = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    m_k = -1;
    exp_rdata = 32'h0;
    #1;
    chk("abort_rdata", bus.rdata,          32'd0);
    chk("abort_oe_n",  32'(bus.SRAM_OE_N), 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    run_txn(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("post_rst_stall", 32'(stall), 32'd9);
    chk("post_rst_data",  bus.rdata,  32'hA5A55A5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Multi-cycle controller between the MEM stage and an off-chip 16-bit asynchronous SRAM; replaces the single-cycle data memory.
- Splits each 32-bit load/store into two 16-bit half-word accesses and holds ready low for the whole access; the top level inverts ready into the pipeline freeze.
- Sits between EXE_reg outputs (ALU result as address, Rm value as store data) and MEM_REG inputs (load data).

Parameters:
- WAIT_CYCLES, 4, SRAM cycles per half-word access; legal range 1..15.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- MEM_R_EN  in  1  load request from MEM stage
- MEM_W_EN  in  1  store request from MEM stage
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (Rm value)
- rdata  out  32  load data, registered
- ready  out  1  1 = no access pending or access completes this cycle; 0 = pipeline must freeze
- SRAM_ADDR  out  SRAM_AW  half-word address
- SRAM_DQ_O  out  16  write data to pad
- SRAM_DQ_I  in  16  read data from pad
- SRAM_DQ_OE  out  1  pad output enable, 1 during writes only
- SRAM_WE_N  out  1  active-low write strobe
- SRAM_OE_N  out  1  active-low output enable

Behaviour:
- Word index: w = (addr - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. addr[1:0] is ignored. Low half-word goes to {w,0}, high half-word to {w,1}.
- States: IDLE, LO, HI, DONE. A counter cnt runs 0..WAIT_CYCLES-1 in LO and HI.
- IDLE:
  - ready = ~(MEM_R_EN | MEM_W_EN), combinational, so a freeze is raised in the same cycle the request appears.
  - On a request, latch w, wdata and op (write if MEM_W_EN, else read), clear cnt, and go to LO.
  - If MEM_R_EN and MEM_W_EN are both 1, the access is a write.
- LO:
  - SRAM_ADDR = {w,0}.
  - Write: SRAM_DQ_O = wdata[15:0], DQ_OE = 1, WE_N = 0 for all cycles except the last, where WE_N = 1 so data hold is met.
  - Read: OE_N = 0; on the last cycle (cnt = WAIT_CYCLES-1) sample SRAM_DQ_I into rdata[15:0].
  - At cnt = WAIT_CYCLES-1, clear cnt and go to HI.
  - ready = 0.
- HI: same as LO using {w,1} and wdata[31:16] / rdata[31:16]. At the last cycle go to DONE. ready = 0.
- DONE: ready = 1 for exactly one cycle; rdata is stable; all SRAM strobes are inactive. Always go to IDLE; a request still asserted in DONE is the completing one and is never restarted.
- Latency: a request first seen in cycle 0 gives ready = 0 in cycles 0..2*WAIT_CYCLES and ready = 1 in cycle 2*WAIT_CYCLES+1. Total stall is 2*WAIT_CYCLES+1 cycles.
- A write never modifies rdata. rdata holds its last load value until the next read overwrites it.
- Inputs are sampled only in IDLE; changes to addr or wdata mid-access are ignored.
- Idle/inactive outputs: WE_N = 1, OE_N = 1, DQ_OE = 0, SRAM_ADDR = 0, DQ_O = 0.
- Reset (rst = 0, at any time including mid-access):
  - state = IDLE, cnt = 0, rdata = 0;
  - WE_N = 1, OE_N = 1, DQ_OE = 0, SRAM_ADDR = 0, DQ_O = 0;
  - ready = 1 when no request is present.
  - An aborted write may leave one half-word written; no recovery is performed.

Test Plan:
- Reset with MEM_R_EN = MEM_W_EN = 0 -> ready = 1, rdata = 0, WE_N = OE_N = 1, DQ_OE = 0.
- Store addr = 1024, wdata = 0xDEADBEEF, WAIT_CYCLES = 4 -> ready = 0 for 9 cycles, then 1 for one cycle; SRAM model holds half-word 0 = 0xBEEF and half-word 1 = 0xDEAD; WE_N low for 3 cycles per half.
- Load addr = 1024 after that store -> rdata = 0xDEADBEEF in the DONE cycle; OE_N low for 8 cycles; DQ_OE stays 0.
- Load addr = 1030 (addr[1:0] = 2'b10) with word 1 preloaded to 0x12345678 -> SRAM_ADDR sequence 2 then 3; rdata = 0x12345678.
- MEM_R_EN = MEM_W_EN = 1, addr = 1028, wdata = 0xA5A5 5A5A -> treated as a write; half-word 2 = 0x5A5A, half-word 3 = 0xA5A5; rdata unchanged.
- rst pulsed low during the HI half of a load -> immediately state IDLE, rdata = 0, strobes inactive; a new load after release completes in 2*WAIT_CYCLES+1 cycles with correct data.
